// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads the word addressed by the PC, holds it for decode over a
// valid/ready handshake, and drives the PC's increment and load (branch redirect) controls.
module fetch_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    output logic             pc_nxt,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_target,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_addr,
    output logic [WIDTH-1:0] ir_out,
    output logic [WIDTH-1:0] ir_pc,
    output logic             ir_valid,
    input  logic             ir_ready,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        REDIR,
        DRAIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] drain_addr;
    logic             redirect_taken;

    // Redirects are meaningless before the first fetch has been launched.
    assign redirect_taken = redirect_valid && (state != IDLE);

    assign mem_req = (state == FETCH) || (state == DRAIN);

    always_comb begin
        mem_addr = '0;
        if (state == FETCH) begin
            mem_addr = pc_in;
        end else if (state == DRAIN) begin
            mem_addr = drain_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            drain_addr  <= '0;
            ir_out      <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            pc_nxt      <= 1'b0;
            pc_load     <= 1'b0;
            pc_target   <= '0;
            fetch_count <= '0;
        end else begin
            pc_nxt  <= 1'b0;
            pc_load <= 1'b0;

            if (redirect_taken) begin
                pc_load   <= 1'b1;
                pc_target <= redirect_addr;
                ir_valid  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= FETCH;
                end

                FETCH: begin
                    if (redirect_taken) begin
                        // A read still in flight must finish before a new one may start.
                        if (mem_ack) begin
                            state <= REDIR;
                        end else begin
                            drain_addr <= pc_in;
                            state      <= DRAIN;
                        end
                    end else if (mem_ack) begin
                        ir_out   <= mem_rdata;
                        ir_pc    <= pc_in;
                        ir_valid <= 1'b1;
                        pc_nxt   <= 1'b1;
                        state    <= HOLD;
                    end
                end

                HOLD: begin
                    if (redirect_taken) begin
                        state <= REDIR;
                    end else if (ir_ready) begin
                        ir_valid    <= 1'b0;
                        fetch_count <= fetch_count + 1'b1;
                        state       <= FETCH;
                    end
                end

                REDIR: begin
                    // Gives the PC one edge to absorb the load before pc_in is sampled.
                    if (!redirect_taken) begin
                        state <= FETCH;
                    end
                end

                DRAIN: begin
                    if (mem_ack) begin
                        state <= redirect_taken ? REDIR : FETCH;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC and variable-latency memory models, scoreboard of delivered words.
module tb_fetch_unit;

    localparam int WIDTH = 16;
    localparam int CNT_W = 3;

    typedef struct {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] ins;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             pc_rst_n;
    logic [WIDTH-1:0] pc;
    logic             pc_nxt;
    logic             pc_load;
    logic [WIDTH-1:0] pc_target;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_addr;
    logic [WIDTH-1:0] ir_out;
    logic [WIDTH-1:0] ir_pc;
    logic             ir_valid;
    logic             ir_ready;
    logic [CNT_W-1:0] fetch_count;

    int   waits;
    int   wcnt;
    int   checks;
    int   failures;
    int   nxt_cnt;
    exp_t sb[$];

    fetch_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc),
        .pc_nxt         (pc_nxt),
        .pc_load        (pc_load),
        .pc_target      (pc_target),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .ir_out         (ir_out),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Program counter; has its own reset so it survives a fetch-unit reset.
    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n)    pc <= '0;
        else if (pc_load) pc <= pc_target;
        else if (pc_nxt)  pc <= pc + 1'b1;
    end

    // Memory: mem[a] = a + 100 after `waits` wait states; drops a request abandoned mid-way.
    always_ff @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end
    assign mem_ack   = mem_req && (wcnt == waits);
    assign mem_rdata = mem_ack ? mem_addr + 16'd100 : 16'hDEAD;

    // Advance one clock; the negedge sample acts as the scoreboard monitor.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rst && ir_valid && ir_ready && !redirect_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got ir_pc=%h ir_out=%h, none expected", ir_pc, ir_out);
            end else begin
                e = sb.pop_front();
                if (ir_pc !== e.pc || ir_out !== e.ins) begin
                    failures++;
                    $display("FAIL sb_delivery: got ir_pc=%h ir_out=%h, expected ir_pc=%h ir_out=%h",
                             ir_pc, ir_out, e.pc, e.ins);
                end
            end
        end
        if (pc_nxt || pc_load) begin
            checks++;
            if (pc_nxt && pc_load) begin
                failures++;
                $display("FAIL nxt_load_exclusive: got pc_nxt=1 pc_load=1, expected at most one");
            end
        end
        if (pc_nxt) nxt_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] a);
        exp_t e;
        e.pc  = a;
        e.ins = a + 16'd100;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            if (sb.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: got %0d words pending, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (ir_out !== 16'h0 || ir_pc !== 16'h0 || ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ir: got ir_out=%h ir_pc=%h ir_valid=%b, expected 0 0 0", ir_out, ir_pc, ir_valid);
        end
        checks++;
        if (pc_nxt !== 1'b0 || pc_load !== 1'b0 || pc_target !== 16'h0) begin
            failures++;
            $display("FAIL reset_pc_ctl: got nxt=%b load=%b target=%h, expected 0 0 0", pc_nxt, pc_load, pc_target);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0 || fetch_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_mem_cnt: got req=%b addr=%h count=%0d, expected 0 0 0", mem_req, mem_addr, fetch_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int n0 = nxt_cnt;
        push(16'h0);
        push(16'h1);
        push(16'h2);
        rst      = 1'b1;
        pc_rst_n = 1'b1;
        wait_drain(40, "basic");
        ir_ready = 1'b0;
        checks++;
        if (fetch_count !== 3'd3) begin
            failures++;
            $display("FAIL basic_count: got %0d, expected 3", fetch_count);
        end
        checks++;
        if (nxt_cnt - n0 !== 3) begin
            failures++;
            $display("FAIL basic_nxt: got %0d pulses, expected 3", nxt_cnt - n0);
        end
    endtask

    task automatic test_stall();
        cycle();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ir_valid !== 1'b1 || ir_pc !== 16'h3 || ir_out !== 16'd103 || mem_req !== 1'b0 || fetch_count !== 3'd3) begin
                failures++;
                $display("FAIL stall_hold: got valid=%b pc=%h out=%h req=%b count=%0d, expected 1 0003 %h 0 3",
                         ir_valid, ir_pc, ir_out, mem_req, fetch_count, 16'd103);
            end
            cycle();
        end
        push(16'h3);
        ir_ready = 1'b1;
        cycle();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h4 || fetch_count !== 3'd4) begin
            failures++;
            $display("FAIL stall_resume: got req=%b addr=%h count=%0d, expected 1 0004 4", mem_req, mem_addr, fetch_count);
        end
    endtask

    task automatic test_wait_states();
        int n0 = nxt_cnt;
        waits = 3;
        for (int a = 4; a < 6; a++) begin
            push(WIDTH'(a));
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== WIDTH'(a) || ir_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL wait_req: got req=%b addr=%h valid=%b, expected 1 %h 0", mem_req, mem_addr, ir_valid, WIDTH'(a));
                end
                cycle();
            end
            checks++;
            if (mem_req !== 1'b0 || ir_valid !== 1'b1 || pc_nxt !== 1'b1) begin
                failures++;
                $display("FAIL wait_hold: got req=%b valid=%b nxt=%b, expected 0 1 1", mem_req, ir_valid, pc_nxt);
            end
            cycle();
        end
        checks++;
        if (nxt_cnt - n0 !== 2 || fetch_count !== 3'd6) begin
            failures++;
            $display("FAIL wait_totals: got nxt=%0d count=%0d, expected 2 6", nxt_cnt - n0, fetch_count);
        end
    endtask

    task automatic test_redirect_fetch();
        int n0 = nxt_cnt;
        waits          = 2;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0040;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (pc_load !== 1'b1 || pc_target !== 16'h0040 || mem_req !== 1'b1 || mem_addr !== 16'h6 || ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_fetch_load: got load=%b target=%h req=%b addr=%h valid=%b, expected 1 0040 1 0006 0",
                     pc_load, pc_target, mem_req, mem_addr, ir_valid);
        end
        cycle();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h6 || pc_load !== 1'b0) begin
            failures++;
            $display("FAIL redir_drain: got req=%b addr=%h load=%b, expected 1 0006 0", mem_req, mem_addr, pc_load);
        end
        push(16'h0040);
        wait_drain(20, "redir_fetch");
        checks++;
        if (nxt_cnt - n0 !== 1 || fetch_count !== 3'd7) begin
            failures++;
            $display("FAIL redir_fetch_totals: got nxt=%0d count=%0d, expected 1 7", nxt_cnt - n0, fetch_count);
        end
    endtask

    task automatic test_redirect_hold();
        int n0;
        waits = 0;
        cycle();
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 16'h0041) begin
            failures++;
            $display("FAIL redir_hold_pre: got valid=%b pc=%h, expected 1 0041", ir_valid, ir_pc);
        end
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0010;
        cycle();
        redirect_valid = 1'b0;
        n0 = nxt_cnt;
        checks++;
        if (ir_valid !== 1'b0 || pc_load !== 1'b1 || pc_target !== 16'h0010 || pc_nxt !== 1'b0 || fetch_count !== 3'd7) begin
            failures++;
            $display("FAIL redir_hold_drop: got valid=%b load=%b target=%h nxt=%b count=%0d, expected 0 1 0010 0 7",
                     ir_valid, pc_load, pc_target, pc_nxt, fetch_count);
        end
        push(16'h0010);
        wait_drain(20, "redir_hold");
        checks++;
        if (nxt_cnt - n0 !== 1 || fetch_count !== 3'd0) begin
            failures++;
            $display("FAIL redir_hold_wrap: got nxt=%0d count=%0d, expected 1 0", nxt_cnt - n0, fetch_count);
        end
    endtask

    task automatic test_reset_mid();
        cycle();
        ir_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ir_valid !== 1'b0 || pc_nxt !== 1'b0 || pc_load !== 1'b0 || mem_req !== 1'b0 || fetch_count !== 3'd0 || ir_pc !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid: got valid=%b nxt=%b load=%b req=%b count=%0d pc=%h, expected all 0",
                     ir_valid, pc_nxt, pc_load, mem_req, fetch_count, ir_pc);
        end
        cycle();
        rst            = 1'b1;
        ir_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0055;
        push(16'h0011);
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (pc_load !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0011) begin
            failures++;
            $display("FAIL idle_redirect: got load=%b req=%b addr=%h, expected 0 1 0011", pc_load, mem_req, mem_addr);
        end
        wait_drain(20, "reset_resume");
        ir_ready = 1'b0;
        checks++;
        if (fetch_count !== 3'd1) begin
            failures++;
            $display("FAIL reset_resume_count: got %0d, expected 1", fetch_count);
        end
        for (int k = 0; k < 4; k++) cycle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        nxt_cnt        = 0;
        waits          = 0;
        rst            = 1'b0;
        pc_rst_n       = 1'b0;
        ir_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_wait_states();
        test_redirect_fetch();
        test_redirect_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Reads the PC value, issues a read to instruction memory with a variable-latency ack, and latches the returned word with its address.
- Presents the word to decode over a valid/ready handshake.
- Drives the PC's increment (nxt) and load controls, including branch redirects from execute.

Parameters:
- WIDTH, 16: data, address and instruction width.
- CNT_W, 16: width of the delivered-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_in  in  WIDTH  current PC value (PC output Q).
- pc_nxt  out  1  one-cycle increment request to the PC.
- pc_load  out  1  one-cycle load request to the PC.
- pc_target  out  WIDTH  load value for the PC, valid while pc_load=1.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  WIDTH  read address.
- mem_rdata  in  WIDTH  read data, valid when mem_ack=1.
- mem_ack  in  1  read complete.
- redirect_valid  in  1  branch/jump taken (one-cycle pulse from execute).
- redirect_addr  in  WIDTH  branch target.
- ir_out  out  WIDTH  fetched instruction.
- ir_pc  out  WIDTH  address ir_out was fetched from.
- ir_valid  out  1  ir_out/ir_pc valid for decode.
- ir_ready  in  1  decode accepts this cycle.
- fetch_count  out  CNT_W  instructions delivered (valid&&ready), wraps to 0.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - ir_out=0, ir_pc=0, ir_valid=0, pc_nxt=0, pc_load=0, pc_target=0, fetch_count=0.
  - mem_req=0, mem_addr=0.
- States: IDLE, FETCH, HOLD, REDIR, DRAIN.
- IDLE: always goes to FETCH on the first edge after reset release.
- mem_req=1 only in FETCH and DRAIN. mem_addr=pc_in (combinational) in FETCH; held at the captured address in DRAIN; 0 in all other states.
- Memory protocol:
  - mem_req is held until mem_ack; exactly one outstanding read at a time.
  - mem_ack may arrive in the request's first cycle (zero wait states) or any later cycle.
- FETCH with mem_ack=1 and no redirect: ir_out<=mem_rdata, ir_pc<=pc_in, ir_valid<=1, pc_nxt<=1 for exactly one cycle, go to HOLD.
- HOLD:
  - ir_valid=1; ir_out and ir_pc are stable.
  - When ir_ready=1: ir_valid<=0, fetch_count<=fetch_count+1, go to FETCH.
  - The PC has incremented by the time FETCH samples pc_in.
  - Minimum latency is 2 cycles per instruction (zero-wait-state memory, decode always ready).
- Redirect (redirect_valid=1), any state except IDLE:
  - pc_load<=1 for one cycle, pc_target<=redirect_addr, ir_valid<=0.
  - An instruction in HOLD is dropped and fetch_count is unchanged, even if ir_ready=1 in the same cycle.
  - From FETCH with mem_ack=0: go to DRAIN.
  - From FETCH with mem_ack=1: go to REDIR; the returned data is discarded and pc_nxt is not asserted.
  - From HOLD or REDIR: go to REDIR.
  - From DRAIN: stay in DRAIN (the newest target wins).
- REDIR: one wait cycle so the PC load takes effect, then FETCH.
- DRAIN:
  - mem_req stays 1 at the old address until mem_ack; the data is discarded and nothing is latched.
  - On mem_ack go to FETCH, or to REDIR if redirect_valid arrives in the same cycle.
- pc_nxt and pc_load are never asserted in the same cycle.
- redirect_valid in IDLE is ignored.
- pc_nxt=1 exactly once per delivered or dropped fetch that completed without a redirect.
- fetch_count wraps from 2^CNT_W-1 to 0.
- Async reset mid-transaction: all outputs return to reset values immediately; an outstanding memory request is abandoned. The memory model must tolerate this.

Test Plan:
- Reset release, pc_in from the PC starting at 0, memory returning mem[a]=a+100 with 0 waits, ir_ready=1:
  - ir_valid pulses with ir_pc=0,1,2 and ir_out=100,101,102.
  - pc_nxt pulses once per fetch; fetch_count=3 after three handshakes.
- Memory with 3 wait states:
  - mem_req held 4 cycles with mem_addr stable.
  - One ir_valid per fetch; no duplicate pc_nxt.
- ir_ready=0 for 5 cycles during HOLD:
  - ir_out and ir_pc stable, ir_valid=1, no new mem_req, fetch_count unchanged.
  - Raising ir_ray=1 completes the handshake and resumes FETCH.
- Redirect to 0x0040 while FETCH is waiting on a 2-wait-state read:
  - pc_load=1 with pc_target=0x0040.
  - The old read completes in DRAIN and is discarded.
  - The next fetch has ir_pc=0x0040.
- Redirect to 0x0010 in HOLD with ir_ready=1 in the same cycle:
  - ir_valid drops, fetch_count unchanged, no pc_nxt.
  - The next delivered ir_pc is 0x0010.
- rst asserted in the middle of HOLD:
  - ir_valid, pc_nxt, pc_load and mem_req go to 0 immediately, fetch_count=0.
  - After release, fetch resumes from the PC value.
